// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter: accepts a word via valid/ready and emits it one bit per clock.
// First bit appears the cycle after the accepting edge; back-to-back words stream with no gap.
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             take;

  assign take    = din_valid & din_ready;
  assign cnt_nxt = bit_cnt + CNT_W'(1);

  // Bit presented next from a word, and the word with that bit consumed.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      din_ready  <= 1'b0;
    end else if (take) begin
      // Load from IDLE or from the last-bit cycle of the previous word.
      state      <= SHIFT;
      sout       <= head(din);
      shreg      <= advance(din);
      bit_cnt    <= '0;
      sout_valid <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      din_ready  <= 1'b0;
    end else if (state == SHIFT && bit_cnt != LAST) begin
      sout       <= head(shreg);
      shreg      <= advance(shreg);
      bit_cnt    <= cnt_nxt;
      done       <= (cnt_nxt == LAST);
      din_ready  <= (cnt_nxt == LAST);
    end else begin
      // Idle, or finishing a word with nothing queued behind it.
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      din_ready  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg: one MSB-first and one LSB-first instance on a shared clock/reset.
module tb_piso_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din_a = '0, din_b = '0;
  logic       din_valid_a = 1'b0, din_valid_b = 1'b0;
  logic       din_ready_a, sout_a, sout_valid_a, busy_a, done_a;
  logic       din_ready_b, sout_b, sout_valid_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(din_valid_a),
    .din_ready(din_ready_a), .sout(sout_a), .sout_valid(sout_valid_a),
    .busy(busy_a), .done(done_a)
  );

  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(din_valid_b),
    .din_ready(din_ready_b), .sout(sout_b), .sout_valid(sout_valid_b),
    .busy(busy_b), .done(done_b)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst_n = 1'b0;
    din_a = 4'hF;
    din_valid_a = 1'b1;
    #2;
    obs = {sout_a, sout_valid_a, busy_a, done_a, din_ready_a};
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 5'b0);
    end
    step(); step();
    rst_n = 1'b1;
    n_checks++;
    if (din_ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 0", din_ready_a);
    end
    step();
    obs = {sout_a, sout_valid_a, busy_a, done_a, din_ready_a};
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL first_edge_no_accept: got %b expected %b", obs, 5'b00001);
    end
    din_valid_a = 1'b0;
    step();
    n_checks++;
    if (sout_valid_a !== 1'b0 || din_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_reset: valid=%b ready=%b expected 0/1", sout_valid_a, din_ready_a);
    end
  endtask

  task automatic test_msb_first();
    logic [3:0] exp_bits;
    exp_bits = 4'b1010;
    din_a = 4'hA;
    din_valid_a = 1'b1;
    step();
    din_valid_a = 1'b0;
    din_a = 4'h5;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (sout_a !== exp_bits[3-k] || sout_valid_a !== 1'b1 || busy_a !== 1'b1 ||
          done_a !== (k == 3) || din_ready_a !== (k == 3)) begin
        n_fail++;
        $display("FAIL msb_bit%0d: sout=%b vld=%b busy=%b done=%b rdy=%b expected sout=%b vld=1 busy=1 done=%b rdy=%b",
                 k, sout_a, sout_valid_a, busy_a, done_a, din_ready_a, exp_bits[3-k], k == 3, k == 3);
      end
      step();
    end
    n_checks++;
    if ({sout_a, sout_valid_a, busy_a, done_a, din_ready_a} !== 5'b00001) begin
      n_fail++;
      $display("FAIL msb_return_idle: got %b expected 00001",
               {sout_a, sout_valid_a, busy_a, done_a, din_ready_a});
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_seq;
    exp_seq = 4'b0101;  // sout order 0,1,0,1 for 4'hA
    din_b = 4'hA;
    din_valid_b = 1'b1;
    step();
    din_valid_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (sout_b !== exp_seq[3-k] || sout_valid_b !== 1'b1 || done_b !== (k == 3)) begin
        n_fail++;
        $display("FAIL lsb_bit%0d: sout=%b vld=%b done=%b expected sout=%b vld=1 done=%b",
                 k, sout_b, sout_valid_b, done_b, exp_seq[3-k], k == 3);
      end
      step();
    end
    n_checks++;
    if (sout_valid_b !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_return_idle: vld=%b busy=%b expected 0/0", sout_valid_b, busy_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq;
    exp_seq = 8'b0110_1100;
    din_a = 4'h6;
    din_valid_a = 1'b1;
    step();
    din_a = 4'hC;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (sout_a !== exp_seq[7-k] || sout_valid_a !== 1'b1 || done_a !== (k == 3 || k == 7)) begin
        n_fail++;
        $display("FAIL b2b_bit%0d: sout=%b vld=%b done=%b expected sout=%b vld=1 done=%b",
                 k, sout_a, sout_valid_a, done_a, exp_seq[7-k], (k == 3 || k == 7));
      end
      if (k == 4) din_valid_a = 1'b0;
      step();
    end
    n_checks++;
    if (sout_valid_a !== 1'b0 || sout_a !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_return_idle: vld=%b sout=%b expected 0/0", sout_valid_a, sout_a);
    end
  endtask

  task automatic test_streaming();
    int         accepted = 0;
    int         idx = 0;
    int         dones = 0;
    logic       rdy_before;
    logic [3:0] w;
    din_a = 4'h0;
    din_valid_a = 1'b1;
    for (int c = 0; c < 48; c++) begin
      rdy_before = din_ready_a;
      step();
      if (rdy_before && din_valid_a) begin
        accepted++;
        if (accepted == 10) din_valid_a = 1'b0;
        else din_a = 4'(2 * accepted);
      end
      if (sout_valid_a) begin
        w = 4'(2 * (idx / 4));
        n_checks++;
        if (idx >= 40 || sout_a !== w[3 - (idx % 4)]) begin
          n_fail++;
          $display("FAIL stream_bit%0d: sout=%b expected %b", idx, sout_a,
                   (idx >= 40) ? 1'b0 : w[3 - (idx % 4)]);
        end
        idx++;
      end
      if (done_a) dones++;
    end
    n_checks++;
    if (idx != 40 || dones != 10) begin
      n_fail++;
      $display("FAIL stream_counts: valid_cycles=%0d dones=%0d expected 40/10", idx, dones);
    end
  endtask

  task automatic test_busy_reject();
    din_a = 4'hF;
    din_valid_a = 1'b1;
    step();
    din_a = 4'h0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (sout_a !== 1'b1 || din_ready_a !== (k == 3) || done_a !== (k == 3)) begin
        n_fail++;
        $display("FAIL reject_bit%0d: sout=%b rdy=%b done=%b expected sout=1 rdy=%b done=%b",
                 k, sout_a, din_ready_a, done_a, k == 3, k == 3);
      end
      step();
    end
    din_valid_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (sout_a !== 1'b0 || sout_valid_a !== 1'b1 || done_a !== (k == 3)) begin
        n_fail++;
        $display("FAIL reject_second_bit%0d: sout=%b vld=%b done=%b expected sout=0 vld=1 done=%b",
                 k, sout_a, sout_valid_a, done_a, k == 3);
      end
      step();
    end
    n_checks++;
    if (sout_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_return_idle: vld=%b expected 0", sout_valid_a);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] exp_seq;
    int         dones = 0;
    din_a = 4'h9;
    din_valid_a = 1'b1;
    step();
    din_valid_a = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (done_a) dones++;
      step();
    end
    // Now presenting bit index 2; pull reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sout_a, sout_valid_a, busy_a, done_a, din_ready_a} !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b expected 00000",
               {sout_a, sout_valid_a, busy_a, done_a, din_ready_a});
    end
    step();
    if (done_a) dones++;
    step();
    if (done_a) dones++;
    rst_n = 1'b1;
    n_checks++;
    if (dones != 0 || din_ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_done: dones=%0d rdy=%b expected 0/0", dones, din_ready_a);
    end
    step();
    n_checks++;
    if (din_ready_a !== 1'b1 || sout_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: rdy=%b vld=%b expected 1/0", din_ready_a, sout_valid_a);
    end
    exp_seq = 4'b0011;
    din_a = 4'h3;
    din_valid_a = 1'b1;
    step();
    din_valid_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (sout_a !== exp_seq[3-k] || sout_valid_a !== 1'b1 || done_a !== (k == 3)) begin
        n_fail++;
        $display("FAIL midreset_new_bit%0d: sout=%b vld=%b done=%b expected sout=%b vld=1 done=%b",
                 k, sout_a, sout_valid_a, done_a, exp_seq[3-k], k == 3);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_streaming();
    test_busy_reject();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
